// File: rtl/sisc_lsu.sv
// sisc_lsu: load/store sequencer between the SISC execute stage and word-addressed data memory
//   Accepts one load/store at a time, shapes the memory write-enable pulse
//   (setup / pulse / hold) and returns a one-cycle response.
//   Optional build macro: SISC_LSU_MERGE_EN (byte-masked read-modify-write stores).
//   Ports:
//     clk, rst_f                 clock, synchronous active-low reset
//     req_valid/req_ready        request handshake
//     req_store/addr/wdata/mask  request payload
//     resp_valid/rdata/err       one-cycle completion pulse with load data / range error
//     read_addr, read_data       combinational memory read port
//     write_addr/data, dm_we     memory write port, commits on dm_we falling edge
module sisc_lsu #(
    parameter int          RD_LAT   = 1,
    parameter int          WE_WIDTH = 1,
    parameter logic [15:0] MAX_ADDR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] read_addr,
    input  logic [31:0] read_data,
    output logic [15:0] write_addr,
    output logic [31:0] write_data,
    output logic        dm_we
);
    localparam int CMAX = RD_LAT > WE_WIDTH ? RD_LAT : WE_WIDTH;
    localparam int CW   = $clog2(CMAX + 1);
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, RESP} state_t;
    state_t        state, state_n, go;
    logic [CW-1:0] cnt;
    logic          st;
    logic [15:0]   addr;
    logic [31:0]   wdata, merged;
    logic          accept, bad;
    assign accept     = req_valid && state == IDLE;
    assign bad        = req_addr > MAX_ADDR;
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
`ifdef SISC_LSU_MERGE_EN
    logic [3:0] mask;
    // partial stores read the word first; an empty mask completes without touching memory
    assign go = bad ? RESP : !req_store ? RD_WAIT : req_mask == 4'h0 ? RESP :
                req_mask != 4'hF ? RD_WAIT : WR_SETUP;
    always_comb begin
        merged = read_data;
        for (int i = 0; i < 4; i++)
            if (mask[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    always_ff @(posedge clk)
        if (!rst_f) mask <= '0;
        else if (accept) mask <= req_mask;
`else
    logic unused_mask;
    assign unused_mask = ^req_mask;
    assign go          = bad ? RESP : req_store ? WR_SETUP : RD_WAIT;
    assign merged      = wdata;
`endif
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = req_valid ? go : IDLE;
            RD_WAIT:  state_n = cnt == CW'(RD_LAT - 1) ? RD_CAP : RD_WAIT;
            RD_CAP:   state_n = st ? WR_SETUP : RESP;
            WR_SETUP: state_n = WR_PULSE;
            WR_PULSE: state_n = cnt == CW'(WE_WIDTH - 1) ? WR_HOLD : WR_PULSE;
            WR_HOLD:  state_n = RESP;
            RESP:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state      <= IDLE;
            cnt        <= '0;
            st         <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            read_addr  <= '0;
            dm_we      <= 1'b0;
            // a reset landing mid-pulse keeps the write port steady so the forced
            // falling edge of dm_we commits the intended word
            if (!dm_we) begin
                write_addr <= '0;
                write_data <= '0;
            end
        end else begin
            state <= state_n;
            cnt   <= state_n == state ? cnt + 1'b1 : '0;
            dm_we <= state_n == WR_PULSE;
            if (accept) begin
                st       <= req_store;
                addr     <= req_addr;
                wdata    <= req_wdata;
                resp_err <= bad;
            end
            if (accept && bad) resp_rdata <= '0;
            if (accept && state_n == RD_WAIT) read_addr <= req_addr;
            if (state == RD_CAP && !st) resp_rdata <= read_data;
            if (state != WR_SETUP && state_n == WR_SETUP) begin
                write_addr <= state == IDLE ? req_addr : addr;
                write_data <= state == IDLE ? req_wdata : merged;
            end
        end
    end
endmodule

// File: tb/tb_sisc_lsu.sv
// tb_sisc_lsu: randomized self-checking bench for sisc_lsu against a word-level memory model
module tb_sisc_lsu;
    localparam int RD_LAT = 1, WE_WIDTH = 2;
    logic        clk = 0, rst_f = 0, req_valid = 0, req_store = 0;
    logic [15:0] req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic [3:0]  req_mask = 0;
    logic        req_ready, resp_valid, resp_err, dm_we;
    logic [31:0] resp_rdata, read_data, write_data;
    logic [15:0] read_addr, write_addr;
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic [31:0] last_rdata = 0;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;
    assign read_data = mem[read_addr];
    always @(negedge dm_we) mem[write_addr] = write_data;

    sisc_lsu #(.RD_LAT(RD_LAT), .WE_WIDTH(WE_WIDTH), .MAX_ADDR(16'hFFFC)) dut (
        .clk(clk), .rst_f(rst_f), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .read_addr(read_addr), .read_data(read_data), .write_addr(write_addr),
        .write_data(write_data), .dm_we(dm_we)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input bit store, input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        int lat, we_n, exp_lat;
        bit bad, wr, stable, seen;
        logic [31:0] exp_w, pwd;
        logic [15:0] ra0, pwa;
        bad = a > 16'hFFFC;
        exp_w = d;
`ifdef SISC_LSU_MERGE_EN
        for (int i = 0; i < 4; i++) if (!m[i]) exp_w[8*i +: 8] = ref_mem[a][8*i +: 8];
        wr = store && !bad && m != 4'h0;
        exp_lat = bad ? 1 : !store ? RD_LAT + 2 : m == 4'h0 ? 1 :
                  m == 4'hF ? WE_WIDTH + 3 : WE_WIDTH + RD_LAT + 4;
`else
        wr = store && !bad;
        exp_lat = bad ? 1 : store ? WE_WIDTH + 3 : RD_LAT + 2;
`endif
        @(negedge clk);
        ra0 = read_addr;
        chk("ready_idle", req_ready, 1);
        req_valid = 1; req_store = store; req_addr = a; req_wdata = d; req_mask = m;
        @(posedge clk);
        #1 req_valid = 0; req_store = 1'($urandom); req_addr = 16'($urandom);
        req_wdata = $urandom; req_mask = 4'($urandom);
        lat = 0; we_n = 0; stable = 1; seen = 0; pwa = write_addr; pwd = write_data;
        do begin
            @(negedge clk);
            lat++;
            if (dm_we) begin
                we_n++;
                if (!seen && (pwa !== a || pwd !== exp_w)) stable = 0;
                seen = 1;
            end
            if (seen && (write_addr !== a || write_data !== exp_w)) stable = 0;
            pwa = write_addr; pwd = write_data;
        end while (!resp_valid && lat < 60);
        chk("latency", lat, exp_lat);
        chk("resp_err", {31'b0, resp_err}, {31'b0, bad});
        chk("we_cycles", we_n, wr ? WE_WIDTH : 0);
        if (bad) last_rdata = 0;
        else if (!store) last_rdata = ref_mem[a];
        else if (wr) ref_mem[a] = exp_w;
        chk("resp_rdata", resp_rdata, last_rdata);
        if (wr) chk("wr_stable", {31'b0, stable}, 1);
        if (wr) chk("mem_word", mem[a], ref_mem[a]);
        if (bad) chk("ra_keep", {16'b0, read_addr}, {16'b0, ra0});
        @(negedge clk);
        chk("resp_pulse", {31'b0, resp_valid}, 0);
    endtask

    initial begin
        int n, rsp;
        bit ok;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin mem[i] = 0; ref_mem[i] = 0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", {31'b0, resp_err}, 0);
        chk("rst_read_addr", {16'b0, read_addr}, 0);
        chk("rst_dm_we", {31'b0, dm_we}, 0);
        chk("rst_write_addr", {16'b0, write_addr}, 0);
        chk("rst_write_data", write_data, 0);
        rst_f = 1;
        mem[16'h0008] = 32'h1234_5678; ref_mem[16'h0008] = 32'h1234_5678;
        do_op(0, 16'h0008, 0, 4'hF);
        do_op(1, 16'h0009, 32'hDEAD_BEEF, 4'hF);
        do_op(0, 16'h0009, 0, 4'hF);
        do_op(0, 16'hFFFE, 0, 4'hF);
        do_op(0, 16'hFFFC, 0, 4'hF);
        do_op(1, 16'hFFFD, 32'h5555_AAAA, 4'hF);
        // request held while busy: store then a queued load of the same word
        @(negedge clk);
        req_valid = 1; req_store = 1; req_addr = 16'h000A; req_wdata = 32'hCAFE_F00D; req_mask = 4'hF;
        @(posedge clk);
        #1 req_store = 0;
        ok = 1; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (req_ready) ok = 0;
        end while (!resp_valid && n < 60);
        chk("busy_ready_low", {31'b0, ok}, 1);
        chk("held_store_lat", n, WE_WIDTH + 3);
        @(negedge clk);
        chk("held_ready_back", {31'b0, req_ready}, 1);
        @(posedge clk);
        #1 req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 60);
        ref_mem[16'h000A] = 32'hCAFE_F00D; last_rdata = 32'hCAFE_F00D;
        chk("held_load_lat", n, RD_LAT + 2);
        chk("held_load_data", resp_rdata, 32'hCAFE_F00D);
        // reset during the write pulse still commits the word
        @(negedge clk);
        req_valid = 1; req_store = 1; req_addr = 16'h0010; req_wdata = 32'h0BAD_C0DE; req_mask = 4'hF;
        @(posedge clk);
        #1 req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!dm_we && n < 60);
        chk("pulse_seen", {31'b0, dm_we}, 1);
        rst_f = 0;
        @(posedge clk);
        #1 rst_f = 1;
        @(negedge clk);
        chk("rstw_dm_we", {31'b0, dm_we}, 0);
        chk("rstw_ready", {31'b0, req_ready}, 1);
        chk("rstw_mem", mem[16'h0010], 32'h0BAD_C0DE);
        rsp = 0;
        repeat (5) begin @(negedge clk); rsp += int'(resp_valid); end
        chk("rstw_no_resp", rsp, 0);
        ref_mem[16'h0010] = 32'h0BAD_C0DE; last_rdata = 0;
        do_op(0, 16'h0010, 0, 4'hF);
`ifdef SISC_LSU_MERGE_EN
        mem[16'h0004] = 32'hAABB_CCDD; ref_mem[16'h0004] = 32'hAABB_CCDD;
        do_op(1, 16'h0004, 32'h1122_3344, 4'b0101);
        chk("merge_word", mem[16'h0004], 32'hAA22_CC44);
        do_op(1, 16'h0004, 32'hFFFF_FFFF, 4'h0);
        chk("merge_none", mem[16'h0004], 32'hAA22_CC44);
`endif
        for (int k = 0; k < 80; k++) begin
            a = $urandom_range(0, 9) == 0 ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 15));
            do_op(1'($urandom_range(0, 1)), a, $urandom,
                  $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sisc_lsu.md
# sisc_lsu

Load/store sequencer sitting between the SISC execute stage and the word-addressed data memory. It accepts one load or store request at a time, drives the memory's read address, write address, write data and write-enable with the required setup and hold, and returns load data or store completion with a one-cycle response pulse. The memory commits a write on the falling edge of its write-enable and reads combinationally, so this block owns all write-enable pulse shaping.

## Interface
- RD_LAT, 1: cycles read_addr is held before read_data is captured (≥1)
- WE_WIDTH, 1: cycles dm_we is held high per write (≥1)
- MAX_ADDR, 16'hFFFC: highest legal word address
- clk  in  1  rising-edge clock
- rst_f  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and accepting
- req_store  in  1  1 = store, 0 = load
- req_addr  in  16  word address
- req_wdata  in  32  store data
- req_mask  in  4  byte enables; bit i covers wdata[8i+7:8i]
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load data, valid with resp_valid
- resp_err  out  1  address out of range, valid with resp_valid
- read_addr  out  16  memory read address
- write_addr  out  16  memory write address
- write_data  out  32  memory write data
- dm_we  out  1  memory write enable; write commits on its 1→0 transition

## Operation
- States: IDLE, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, RESP.
- IDLE: req_ready=1. Handshake = req_valid & req_ready at rising edge; addr/wdata/mask/store latched.
- Range check at accept: req_addr > MAX_ADDR → RESP with resp_err=1, resp_rdata=0, no memory access, dm_we stays 0.
- Load: read_addr=latched addr; RD_WAIT for RD_LAT cycles; RD_CAP samples read_data into resp_rdata; RESP.
- Store: WR_SETUP (addr/data driven, dm_we=0, 1 cycle) → WR_PULSE (dm_we=1, WE_WIDTH cycles) → WR_HOLD (dm_we=0, addr/data unchanged, 1 cycle) → RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every state but IDLE.
- write_addr/write_data change only in IDLE→WR_SETUP; stable through WR_HOLD.
- read_addr tracks the latched address for loads; stores leave it unchanged.
- resp_rdata holds its last value until the next load capture; resp_err cleared at each accept.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, read_addr=0, dm_we=0, state IDLE.
- write_addr/write_data reset to 0, except when reset is sampled while dm_we=1: they then hold for that cycle, so the forced 1→0 edge commits the intended word rather than corrupting address 0. That write is considered done; no resp_valid is issued.
- Load latency, accept edge to resp_valid high: RD_LAT+2 cycles (RD_LAT=1 → 3).
- Store latency: WE_WIDTH+3 cycles (WE_WIDTH=1 → 4).
- Error latency: 1 cycle.
- Back-to-back: the next accept is possible in the cycle after RESP (IDLE). Maximum throughput is one request per latency+1 cycles.
- req_valid while busy is ignored; the requester must hold it until accepted.

## Configuration
- SISC_LSU_MERGE_EN defined: a store with req_mask≠4'hF first runs RD_WAIT/RD_CAP on the same address. Merged word = masked bytes from req_wdata, remaining bytes from memory. The merged word then goes through WR_SETUP/WR_PULSE/WR_HOLD. Adds RD_LAT+1 cycles to latency. req_mask=4'h0 completes via RESP with no write and dm_we never asserted.
- Undefined: req_mask is ignored and every store writes the full 32-bit word.

## Test plan
- Load addr 16'h0008 holding 32'h1234_5678, RD_LAT=1 → resp_valid 3 cycles after accept, resp_rdata=32'h1234_5678, resp_err=0, dm_we never 1.
- Store 32'hDEAD_BEEF to 16'h0009, WE_WIDTH=2 → dm_we high exactly 2 cycles, write_addr/write_data stable from setup through hold, resp_valid at cycle 5; a following load returns 32'hDEAD_BEEF.
- Load addr 16'hFFFE → resp_valid next cycle, resp_err=1, resp_rdata=0, read_addr and dm_we unchanged.
- req_valid held during a store → not accepted until IDLE; req_ready low throughout; second request served in order.
- rst_f low in the WR_PULSE cycle of a store to 16'h0010 → dm_we=0 next cycle, memory[16'h0010] holds the new word, no resp_valid, req_ready=1.
- SISC_LSU_MERGE_EN: memory[4]=32'hAABB_CCDD, store 32'h1122_3344 with mask 4'b0101 → memory[4]=32'hAA22_CC44, latency 6 cycles.
